mod_exp: RTL and testbench

Modular exponentiation controller: computes z = x^e mod m by sequencing a single embedded `mod_mul` Montgomery multiplier (z = a·b·R⁻¹ mod m, R = 2^k) through domain entry, left-to-right square-and-multiply, and domain exit. It is the initiator of the `mod_mul` start/done handshake and is the RSA/ECC-side front end that the rest of the datapath calls. Runtime is data-dependent only through popcount(e).

---
 rtl/mod_exp.sv | 195 +++++++++++++++++++
 tb/tb_mod_exp.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mod_exp.sv
// rtl/mod_exp.sv - modular exponentiation controller around a bit-serial Montgomery multiplier
// z = x^e mod m via domain entry, left-to-right square-and-multiply over all k exponent bits, domain exit.

module mod_mul #(
   parameter int k = 192,
   parameter int logk = 8,
   parameter logic [k-1:0] m = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [k-1:0] x,
   input  logic [k-1:0] y,
   output logic [k-1:0] z,
   output logic         done
);
   localparam logic [logk-1:0] last = logk'(k - 1);

   logic [k-1:0]    a;
   logic [k-1:0]    b;
   logic [k+1:0]    acc;
   logic [k+1:0]    s1;
   logic [k+1:0]    s2;
   logic [k+1:0]    nxt;
   logic [k-1:0]    red;
   logic [logk-1:0] cnt;
   logic            run;
   logic            ge;

   // acc stays below m + b < 2m, so one conditional subtract fully reduces the result
   always_comb begin
      s1  = acc + {2'b00, (a[0] ? b : {k{1'b0}})};
      s2  = s1[0] ? s1 + {2'b00, m} : s1;
      nxt = s2 >> 1;
      ge  = (nxt >= {2'b00, m});
      red = ge ? nxt[k-1:0] - m : nxt[k-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a    <= '0;
         b    <= '0;
         acc  <= '0;
         cnt  <= '0;
         run  <= 1'b0;
         done <= 1'b0;
         z    <= '0;
      end else if (run) begin
         a   <= a >> 1;
         acc <= nxt;
         if (cnt == last) begin
            run  <= 1'b0;
            done <= 1'b1;
            z    <= red;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else if (done) begin
         if (!start) done <= 1'b0;
      end else if (start) begin
         a   <= x;
         b   <= y;
         acc <= '0;
         cnt <= '0;
         run <= 1'b1;
      end
   end
endmodule

module mod_exp #(
   parameter int k = 192,
   parameter int logk = 8,
   parameter logic [k-1:0] m = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff,
   parameter logic [k-1:0] r2 = 192'h000000000000000100000000000000020000000000000001
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [k-1:0] x,
   input  logic [k-1:0] e,
   output logic [k-1:0] z,
   output logic         done,
   output logic         busy
);
   localparam logic [2:0] s_idle   = 3'd0;
   localparam logic [2:0] s_to_x   = 3'd1;
   localparam logic [2:0] s_to_one = 3'd2;
   localparam logic [2:0] s_sqr    = 3'd3;
   localparam logic [2:0] s_mul    = 3'd4;
   localparam logic [2:0] s_from   = 3'd5;
   localparam logic [2:0] s_done   = 3'd6;
   localparam logic [logk-1:0] last = logk'(k - 1);
   localparam logic [k-1:0] one = {{(k-1){1'b0}}, 1'b1};

   logic [2:0]      state;
   logic            rel;
   logic [k-1:0]    e_r;
   logic [logk-1:0] idx;
   logic [k-1:0]    xm;
   logic [k-1:0]    acc;
   logic [k-1:0]    mul_x;
   logic [k-1:0]    mul_y;
   logic [k-1:0]    mul_z;
   logic            mul_start;
   logic            mul_done;

   mod_mul #(.k(k), .logk(logk), .m(m)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mul_start),
      .x     (mul_x),
      .y     (mul_y),
      .z     (mul_z),
      .done  (mul_done)
   );

   // rel=0: product in flight, capture on mul_done; rel=1: wait for mul_done to drop,
   // then consume acc and issue the next product on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= s_idle;
         rel       <= 1'b0;
         e_r       <= '0;
         idx       <= '0;
         xm        <= '0;
         acc       <= '0;
         mul_x     <= '0;
         mul_y     <= '0;
         mul_start <= 1'b0;
         z         <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            s_idle: if (start) begin
               e_r       <= e;
               idx       <= last;
               busy      <= 1'b1;
               mul_x     <= x;
               mul_y     <= r2;
               mul_start <= 1'b1;
               rel       <= 1'b0;
               state     <= s_to_x;
            end
            s_done: if (!start) begin
               done  <= 1'b0;
               state <= s_idle;
            end
            default: if (!rel) begin
               if (mul_done) begin
                  acc       <= mul_z;
                  mul_start <= 1'b0;
                  rel       <= 1'b1;
               end
            end else if (!mul_done) begin
               rel       <= 1'b0;
               mul_start <= (state != s_from);
               case (state)
                  s_to_x: begin
                     xm    <= acc;
                     mul_x <= r2;
                     mul_y <= one;
                     state <= s_to_one;
                  end
                  s_to_one: begin
                     mul_x <= acc;
                     mul_y <= acc;
                     state <= s_sqr;
                  end
                  s_sqr, s_mul: begin
                     mul_x <= acc;
                     if (state == s_sqr && e_r[idx]) begin
                        mul_y <= xm;
                        state <= s_mul;
                     end else if (idx == '0) begin
                        mul_y <= one;
                        state <= s_from;
                     end else begin
                        idx   <= idx - 1'b1;
                        mul_y <= acc;
                        state <= s_sqr;
                     end
                  end
                  default: begin
                     z     <= acc;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= s_done;
                  end
               endcase
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mod_exp.sv
// tb/tb_mod_exp.sv - directed bench for mod_exp
// Uses k=16 with the prime m=65521 (R mod m = 15, R^2 mod m = 225) so every run stays short.

module tb_mod_exp;
   localparam int K = 16;
   localparam int LOGK = 4;
   localparam logic [K-1:0] M = 16'd65521;
   localparam logic [K-1:0] R2 = 16'd225;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [K-1:0] x;
   logic [K-1:0] e;
   logic [K-1:0] z;
   logic         done;
   logic         busy;

   int   tests;
   int   fails;
   int   prods;
   logic p_start;
   logic p_done;
   logic [K-1:0] p_x;
   logic [K-1:0] p_y;

   mod_exp #(.k(K), .logk(LOGK), .m(M), .r2(R2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .x     (x),
      .e     (e),
      .z     (z),
      .done  (done),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sample_prev();
      p_start = dut.mul_start;
      p_done  = dut.mul_done;
      p_x     = dut.mul_x;
      p_y     = dut.mul_y;
   endtask

   // one clock, then handshake monitoring on the freshly updated multiplier interface
   task automatic tick();
      @(posedge clk);
      #1;
      if (dut.mul_start && !p_start) begin
         prods++;
         chk("start_while_done", p_done, 1'b0);
      end
      if (dut.mul_start && p_start) begin
         chk("mul_x_stable", dut.mul_x, p_x);
         chk("mul_y_stable", dut.mul_y, p_y);
      end
      sample_prev();
   endtask

   task automatic run(input logic [K-1:0] xi, input logic [K-1:0] ei, input logic [K-1:0] zexp,
                      input int hold, input bit disturb);
      int n;
      int cyc;
      n = 3 + K + $countones(ei);
      x = xi;
      e = ei;
      start = 1'b1;
      prods = 0;
      tick();
      chk("busy_on_accept", busy, 1'b1);
      cyc = 0;
      while (!done && cyc < 4000) begin
         if (disturb && cyc < 30) begin
            start = cyc[0];
            x = 16'h1234;
            e = 16'hffff;
         end else begin
            start = 1'b1;
         end
         tick();
         cyc++;
      end
      chk("done_rise", done, 1'b1);
      chk("latency", cyc, n * (K + 4));
      chk("busy_at_done", busy, 1'b0);
      chk("z", z, zexp);
      chk("product_count", prods, n);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("done_hold", done, 1'b1);
         chk("z_hold", z, zexp);
      end
      start = 1'b0;
      tick();
      chk("done_fall", done, 1'b0);
      chk("busy_idle", busy, 1'b0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      prods = 0;
      rst_n = 1'b0;
      start = 1'b0;
      x = '0;
      e = '0;
      #1;
      sample_prev();
      chk("reset_z", z, 16'd0);
      chk("reset_done", done, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_mul_start", dut.mul_start, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      run(16'd2, 16'd3, 16'd8, 0, 1'b0);
      run(16'd5, 16'd1, 16'd5, 0, 1'b1);
      run(16'd0, 16'd7, 16'd0, 0, 1'b0);
      run(16'd0, 16'd0, 16'd1, 0, 1'b0);
      run(16'd7, 16'd0, 16'd1, 0, 1'b0);
      run(16'd65520, 16'd2, 16'd1, 0, 1'b0);
      run(16'd3, 16'd65520, 16'd1, 0, 1'b0);
      run(16'd3, 16'd16, 16'd64945, 10, 1'b0);
      run(16'd2, 16'd10, 16'd1024, 0, 1'b0);

      // abort in the middle of the first squaring
      x = 16'd2;
      e = 16'd3;
      start = 1'b1;
      tick();
      for (int i = 0; i < 50; i++) tick();
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      chk("abort_z", z, 16'd0);
      chk("abort_done", done, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_mul_start", dut.mul_start, 1'b0);
      chk("abort_mul_done", dut.mul_done, 1'b0);
      sample_prev();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("after_abort_idle", busy, 1'b0);
      run(16'd2, 16'd3, 16'd8, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
